// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_pkg;

    localparam int unsigned DEPTH_DEFAULT = 2;
    localparam int unsigned INSTR_W       = 16;
    localparam int unsigned BYTE_W        = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_HI = 2'd1,
        FETCH_LO = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Small circular queue of fetched instructions, each tagged with its word address.
module fetch_queue #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned TAG_W  = 8,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [TAG_W-1:0]  push_tag,
    input  logic [DATA_W-1:0] push_instr,
    output logic [CNT_W-1:0]  count,
    output logic [TAG_W-1:0]  head_tag,
    output logic [DATA_W-1:0] head_instr
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][TAG_W-1:0]  tag_mem;
    logic [DEPTH-1:0][DATA_W-1:0] instr_mem;
    logic [PTR_W-1:0]             rd_ptr;
    logic [PTR_W-1:0]             wr_ptr;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            tag_mem   <= '0;
            instr_mem <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr]   <= push_tag;
                instr_mem[wr_ptr] <= push_instr;
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign head_tag   = tag_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction prefetcher: assembles 16-bit instructions from a byte-wide ROM
// into a tagged queue and redirects whenever the CPU's pc leaves the stream.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic               mem_req,
    output logic [ADDR_W:0]    mem_addr,
    input  logic [BYTE_W-1:0]  mem_data,
    input  logic               mem_ack
);

    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned CNT1_W = CNT_W + 1;

    fetch_state_e        state;
    fetch_state_e        state_nxt;
    logic [ADDR_W-1:0]   fetch_pc;
    logic [ADDR_W-1:0]   fetch_pc_nxt;
    logic [BYTE_W-1:0]   hi_byte;
    logic [BYTE_W-1:0]   hi_byte_nxt;

    logic [CNT_W-1:0]    count;
    logic [ADDR_W-1:0]   head_tag;
    logic [INSTR_W-1:0]  head_instr;
    logic [ADDR_W-1:0]   expected_pc;
    logic [CNT1_W-1:0]   count_after;
    logic                redirect;
    logic                push;
    logic                pop;

    fetch_queue #(
        .DEPTH  (DEPTH),
        .TAG_W  (ADDR_W),
        .DATA_W (INSTR_W),
        .CNT_W  (CNT_W)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (redirect),
        .push_tag   (fetch_pc),
        .push_instr ({hi_byte, mem_data}),
        .count      (count),
        .head_tag   (head_tag),
        .head_instr (head_instr)
    );

    // The stream is on track only if the next address we can offer equals pc.
    assign expected_pc = (count != '0) ? head_tag : fetch_pc;
    assign redirect    = (expected_pc != pc);
    assign ir          = head_instr;
    assign ir_valid    = (count != '0) && (head_tag == pc);
    assign pop         = ir_valid && ir_ready;
    assign count_after = CNT1_W'(count) + CNT1_W'(1) - CNT1_W'(pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            fetch_pc <= '0;
            hi_byte  <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            hi_byte  <= hi_byte_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        hi_byte_nxt  = hi_byte;
        push         = 1'b0;
        mem_req      = 1'b0;
        mem_addr     = '0;
        case (state)
            IDLE: begin
                if (count < CNT_W'(DEPTH)) begin
                    state_nxt = FETCH_HI;
                end
            end
            FETCH_HI: begin
                mem_req  = 1'b1;
                mem_addr = {fetch_pc, 1'b0};
                if (mem_ack) begin
                    hi_byte_nxt = mem_data;
                    state_nxt   = FETCH_LO;
                end
            end
            FETCH_LO: begin
                mem_req  = 1'b1;
                mem_addr = {fetch_pc, 1'b1};
                if (mem_ack) begin
                    push         = 1'b1;
                    fetch_pc_nxt = fetch_pc + ADDR_W'(1);
                    state_nxt    = (count_after < CNT1_W'(DEPTH)) ? FETCH_HI : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A redirect discards this cycle's ack and restarts at pc.
        if (redirect) begin
            push         = 1'b0;
            hi_byte_nxt  = hi_byte;
            fetch_pc_nxt = pc;
            state_nxt    = FETCH_HI;
        end
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_W, default 8: width of the instruction word address (CPU program counter).
REQ-002 Parameter DEPTH, default 2: number of entries in the instruction queue.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 reset  input  1: asynchronous, active-low reset (0 = reset asserted).
REQ-005 pc  input  ADDR_W: word address of the instruction the CPU currently wants.
REQ-006 ir  output  16: instruction at queue head.
REQ-007 ir_valid  output  1: ir is valid and belongs to address pc.
REQ-008 ir_ready  input  1: consumer accepts ir this cycle.
REQ-009 mem_req  output  1: byte read request to the byte-wide instruction ROM.
REQ-010 mem_addr  output  ADDR_W+1: byte address, {fetch_pc, byte_sel}.
REQ-011 mem_data  input  8: ROM read data, sampled only when mem_ack=1.
REQ-012 mem_ack  input  1: mem_data valid; completes the current byte request.

Function
REQ-013 Each 16-bit instruction SHALL be fetched as two byte reads: high byte at {fetch_pc,0}, then low byte at {fetch_pc,1} (big-endian).
REQ-014 FSM states SHALL be IDLE, FETCH_HI and FETCH_LO.
REQ-015 IDLE -> FETCH_HI when count < DEPTH and no redirect; otherwise stay in IDLE.
REQ-016 FETCH_HI: mem_req=1, mem_addr={fetch_pc,0}; on mem_ack, latch mem_data as hi_byte and go to FETCH_LO.
REQ-017 FETCH_LO: mem_req=1, mem_addr={fetch_pc,1}; on mem_ack, push {tag=fetch_pc, instr={hi_byte,mem_data}}, fetch_pc <= fetch_pc+1 (wraps 2^ADDR_W-1 -> 0), then go to FETCH_HI if count after push < DEPTH, else IDLE.
REQ-018 Without mem_ack, mem_req and mem_addr SHALL remain stable; in IDLE, mem_req=0 and mem_addr=0.
REQ-019 ir SHALL be the head entry's instruction; ir_valid = (count != 0) && (head tag == pc).
REQ-020 Pop occurs when ir_valid && ir_ready; push and pop in the same cycle leave count unchanged.
REQ-021 Redirect SHALL occur when the expected address (head tag if count != 0, else fetch_pc) differs from pc.
REQ-022 On redirect: count <= 0, fetch_pc <= pc, FSM -> FETCH_HI, and any mem_ack in that cycle is discarded.
REQ-023 Redirect SHALL take priority over both push and pop.
REQ-024 Ideal-ROM throughput (mem_ack tied high) SHALL be one instruction every 2 cycles.
REQ-025 First ir_valid SHALL occur no earlier than 3 rising edges after reset deassertion.
REQ-026 Pushes SHALL never occur when count == DEPTH; this holds by construction because only one instruction is in flight and a fetch starts only when count < DEPTH.

Reset
REQ-027 While reset=0: FSM=IDLE, count=0, fetch_pc=0, hi_byte=0, ir=0, ir_valid=0, mem_req=0, mem_addr=0; these take effect immediately, independent of clk.
REQ-028 Reset asserted mid-fetch SHALL abandon the request; mem_ack while reset=0 is ignored.

Structure
REQ-029 Package instr_fetch_pkg SHALL hold the FSM state enum, the DEPTH default, and the instruction/byte width constants.
REQ-030 Queue storage SHALL be a sub-module, fetch_queue (DEPTH entries of {tag, instr}, with push/pop/flush, count, and head outputs).
REQ-031 The control FSM and the redirect logic SHALL reside in instr_fetch.

Verification
REQ-032 The bench SHALL cover: reset released, pc=0, mem_ack=1, ROM[0]=8'h98, ROM[1]=8'h45 -> mem_addr 0 then 1; ir=16'h9845 with ir_valid=1 by the 3rd edge.
REQ-033 The bench SHALL cover: ir_ready=0 with continuous ack -> two instructions queued (tags 0, 1), then FSM in IDLE with mem_req=0; raising ir_ready and incrementing pc -> pops in order.
REQ-034 The bench SHALL cover: queue holds tags 3 and 4, pc changes to 8'h20 -> next cycle ir_valid=0, mem_addr=9'h040, and the next instruction pushed has tag 8'h20.
REQ-035 The bench SHALL cover: mem_ack held low for 5 cycles in FETCH_LO -> mem_addr stays {fetch_pc,1} and no push occurs until mem_ack rises.
REQ-036 The bench SHALL cover: pc=8'hFF fetched -> mem_addr 9'h1FE then 9'h1FF, and fetch_pc wraps to 0 for the prefetched entry.
REQ-037 The bench SHALL cover: reset pulsed low during FETCH_HI -> mem_req drops immediately, count=0, and after release fetching restarts at current pc with the old ack discarded.
